// File: rtl/restoring_divider.sv
// restoring_divider: sequential 8-bit restoring divider, one quotient bit per clock.
// Q holds the dividend and then the quotient. R holds the remainder. M holds the divisor.
// A start in IDLE runs exactly one operation. The FSM then parks in DONE until Run drops.
// Optional feature macro: DIV_SIGNED_EN. It selects two's-complement operands and adds the FIX state.
// Reset is synchronous and active-high on Clk.
module restoring_divider (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       ClearR_LoadQ,
    input  logic       LoadM,
    input  logic [7:0] Din,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic [7:0] M,
    output logic       Busy,
    output logic       Done,
    output logic       DivZero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] S_FIX  = 2'd2;
`endif
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state;
    logic [2:0] cnt;

`ifdef DIV_SIGNED_EN
    logic       sign_q;
    logic       sign_m;
    logic [7:0] q_mag;
    logic [7:0] m_mag;
`endif

    // {R, Q} shifted left by one. The 9-bit partial remainder keeps the carry-out of R.
    logic [8:0] rs;
    logic [8:0] trial;
    logic       trial_ok;

    // One restoring step: shift, trial subtract, and keep the difference only if it did not go negative.
    always_comb begin
        rs       = {R, Q[7]};
        trial    = rs - {1'b0, M};
        // R < M holds throughout an iteration, so rs < 2*M.
        // The 9-bit difference is therefore below 256 exactly when it is non-negative.
        trial_ok = ~trial[8];
`ifdef DIV_SIGNED_EN
        // Negating 8'h80 gives 8'h80, which reads as unsigned 128.
        q_mag    = Q[7] ? (8'd0 - Q) : Q;
        m_mag    = M[7] ? (8'd0 - M) : M;
`endif
    end

    // Status outputs decode directly from the state register.
    always_comb begin
`ifdef DIV_SIGNED_EN
        Busy = (state == S_ITER) || (state == S_FIX);
`else
        Busy = (state == S_ITER);
`endif
        Done = (state == S_DONE);
    end

    // Control FSM together with the Q/R/M datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Q       <= '0;
            R       <= '0;
            M       <= '0;
            DivZero <= 1'b0;
`ifdef DIV_SIGNED_EN
            sign_q  <= 1'b0;
            sign_m  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Run) begin
                        if (M == '0) begin
                            Q       <= '1;
                            R       <= Q;
                            DivZero <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            R       <= '0;
                            DivZero <= 1'b0;
                            cnt     <= '0;
                            state   <= S_ITER;
`ifdef DIV_SIGNED_EN
                            sign_q  <= Q[7];
                            sign_m  <= M[7];
                            Q       <= q_mag;
                            M       <= m_mag;
`endif
                        end
                    end else begin
                        if (ClearR_LoadQ) begin
                            Q       <= Din;
                            R       <= '0;
                            DivZero <= 1'b0;
                        end
                        if (LoadM) begin
                            M <= Din;
                        end
                    end
                end

                S_ITER: begin
                    if (trial_ok) begin
                        R <= trial[7:0];
                        Q <= {Q[6:0], 1'b1};
                    end else begin
                        R <= rs[7:0];
                        Q <= {Q[6:0], 1'b0};
                    end
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
`ifdef DIV_SIGNED_EN
                        state <= S_FIX;
`else
                        state <= S_DONE;
`endif
                    end
                end

`ifdef DIV_SIGNED_EN
                S_FIX: begin
                    if (sign_q ^ sign_m) begin
                        Q <= 8'd0 - Q;
                    end
                    if (sign_q) begin
                        R <= 8'd0 - R;
                    end
                    state <= S_DONE;
                end
`endif

                S_DONE: begin
                    if (!Run) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: directed bench for restoring_divider.
// An arithmetic model predicts each operation's result and the cycle on which Done rises.
// A negedge compare process checks the outputs against it every cycle.
// Literal checks pin the model. The signed cases are built when DIV_SIGNED_EN is defined.
module tb_restoring_divider;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run;
    logic       ClearR_LoadQ;
    logic       LoadM;
    logic [7:0] Din;
    logic [7:0] Q;
    logic [7:0] R;
    logic [7:0] M;
    logic       Busy;
    logic       Done;
    logic       DivZero;

    restoring_divider dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearR_LoadQ (ClearR_LoadQ),
        .LoadM        (LoadM),
        .Din          (Din),
        .Q            (Q),
        .R            (R),
        .M            (M),
        .Busy         (Busy),
        .Done         (Done),
        .DivZero      (DivZero)
    );

    always #5 Clk = ~Clk;

`ifdef DIV_SIGNED_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural register contents as the model sees them.
    logic [7:0] mq, mr, mm;
    logic       mdz;

    // Expected outputs for the current cycle.
    logic       e_chk = 1'b0;
    logic       e_qr;
    logic       e_busy, e_done, e_dz;
    logic [7:0] e_q, e_r, e_m;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Compares every output against the model at mid-cycle.
    always @(negedge Clk) begin
        if (e_chk) begin
            chk("Busy", {7'd0, Busy}, {7'd0, e_busy});
            chk("Done", {7'd0, Done}, {7'd0, e_done});
            chk("DivZero", {7'd0, DivZero}, {7'd0, e_dz});
            chk("M", M, e_m);
            if (e_qr) begin
                chk("Q", Q, e_q);
                chk("R", R, e_r);
            end
        end
    end

    // Result of a divide, computed directly from the operand values.
    function automatic void model_div(input logic [7:0] a, input logic [7:0] b,
                                      output logic [7:0] q, output logic [7:0] r,
                                      output logic [7:0] m_after, output logic dz);
        int sa, sb;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; m_after = b; dz = 1'b1;
        end else begin
            dz = 1'b0;
`ifdef DIV_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q = 8'(sa / sb);
            r = 8'(sa % sb);
            m_after = 8'((sb < 0) ? -sb : sb);
`else
            sa = int'(a);
            sb = int'(b);
            q = 8'(sa / sb);
            r = 8'(sa % sb);
            m_after = b;
`endif
        end
    endfunction

    task automatic set_exp(input logic b, input logic d, input logic z,
                           input logic [7:0] q, input logic [7:0] r, input logic [7:0] m,
                           input logic qr);
        e_busy = b; e_done = d; e_dz = z; e_q = q; e_r = r; e_m = m; e_qr = qr;
        e_chk = 1'b1;
    endtask

    task automatic edge_wait();
        @(posedge Clk);
        #1;
    endtask

    task automatic load(input logic lq, input logic lm, input logic [7:0] d);
        ClearR_LoadQ = lq; LoadM = lm; Din = d;
        edge_wait();
        ClearR_LoadQ = 1'b0; LoadM = 1'b0;
        if (lq) begin mq = d; mr = 8'd0; mdz = 1'b0; end
        if (lm) mm = d;
        set_exp(1'b0, 1'b0, mdz, mq, mr, mm, 1'b1);
    endtask

    // Holds Run high for edges 1..run_cycles.
    // junk drives loads throughout the operation; they must all be ignored.
    // abort_at > 0 pulses Reset on that edge.
    task automatic op(input int run_cycles, input bit junk, input int abort_at);
        logic [7:0] fq, fr, fm;
        logic       fdz;
        int         d, last;
        model_div(mq, mm, fq, fr, fm, fdz);
        d    = fdz ? 1 : LAT;
        last = ((run_cycles > d) ? run_cycles : d) + 1;
        for (int n = 1; n <= last; n++) begin
            Run   = (n <= run_cycles);
            Reset = (n == abort_at);
            if (junk) begin LoadM = 1'b1; ClearR_LoadQ = 1'b1; Din = 8'd3; end
            edge_wait();
            if (n == abort_at) begin
                Reset = 1'b0; Run = 1'b0; LoadM = 1'b0; ClearR_LoadQ = 1'b0;
                mq = 8'd0; mr = 8'd0; mm = 8'd0; mdz = 1'b0;
                set_exp(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
                return;
            end
            if (n >= d)
                set_exp(1'b0, (n == d) || (n <= run_cycles), fdz, fq, fr, fm, 1'b1);
            else
                set_exp(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, fm, 1'b0);
        end
        Run = 1'b0; LoadM = 1'b0; ClearR_LoadQ = 1'b0;
        mq = fq; mr = fr; mm = fm; mdz = fdz;
    endtask

    initial begin
        Reset = 1'b1; Run = 1'b0; ClearR_LoadQ = 1'b0; LoadM = 1'b0; Din = 8'd0;
        mq = 8'd0; mr = 8'd0; mm = 8'd0; mdz = 1'b0;
        edge_wait();
        edge_wait();
        set_exp(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b1);
        Reset = 1'b0;
        edge_wait();

        // 100 / 7, Run held for 20 cycles past Done
        load(1'b1, 1'b0, 8'd100);
        load(1'b0, 1'b1, 8'd7);
        op(29, 1'b0, 0);
        chk("lit_100_7_q", Q, 8'd14);
        chk("lit_100_7_r", R, 8'd2);

        // rerun on held registers: 14 / 7
        op(1, 1'b0, 0);
        chk("lit_14_7_q", Q, 8'd2);
        chk("lit_14_7_r", R, 8'd0);

        // simultaneous loads, then 255 / 1
        load(1'b1, 1'b1, 8'd1);
        load(1'b1, 1'b0, 8'd255);
        op(1, 1'b0, 0);
        chk("lit_255_1_q", Q, 8'hFF);
        chk("lit_255_1_r", R, 8'd0);

        load(1'b1, 1'b0, 8'd0);
        load(1'b0, 1'b1, 8'd5);
        op(2, 1'b0, 0);
        chk("lit_0_5_q", Q, 8'd0);

        load(1'b1, 1'b0, 8'd200);
        load(1'b0, 1'b1, 8'd201);
        op(1, 1'b0, 0);
`ifndef DIV_SIGNED_EN
        chk("lit_200_201_q", Q, 8'd0);
        chk("lit_200_201_r", R, 8'd200);
`endif

        load(1'b1, 1'b0, 8'd250);
        load(1'b0, 1'b1, 8'd16);
        op(1, 1'b0, 0);
        load(1'b1, 1'b0, 8'd128);
        load(1'b0, 1'b1, 8'd3);
        op(1, 1'b0, 0);

        // divide by zero, then a Q load clears DivZero
        load(1'b1, 1'b1, 8'd0);
        load(1'b1, 1'b0, 8'd37);
        op(1, 1'b0, 0);
        chk("lit_dz_q", Q, 8'hFF);
        chk("lit_dz_r", R, 8'd37);
        chk("lit_dz_flag", {7'd0, DivZero}, 8'd1);
        load(1'b1, 1'b0, 8'd9);
        chk("lit_dz_clear", {7'd0, DivZero}, 8'd0);
        chk("lit_dz_q9", Q, 8'd9);

        // Reset mid-iteration with cnt == 4, then 50 / 6
        load(1'b1, 1'b1, 8'd7);
        load(1'b1, 1'b0, 8'd100);
        op(1, 1'b0, 6);
        chk("lit_abort_busy", {7'd0, Busy}, 8'd0);
        edge_wait();
        load(1'b1, 1'b0, 8'd50);
        load(1'b0, 1'b1, 8'd6);
        op(1, 1'b0, 0);
        chk("lit_50_6_q", Q, 8'd8);
        chk("lit_50_6_r", R, 8'd2);

        // loads toggled during ITER/DONE are ignored
        load(1'b1, 1'b1, 8'd7);
        load(1'b1, 1'b0, 8'd100);
        op(3, 1'b1, 0);
        chk("lit_junk_m", M, 8'd7);
        chk("lit_junk_q", Q, 8'd14);

`ifdef DIV_SIGNED_EN
        load(1'b1, 1'b1, 8'd7);
        load(1'b1, 1'b0, 8'h9C);
        op(1, 1'b0, 0);
        chk("lit_sn100_7_q", Q, 8'hF2);
        chk("lit_sn100_7_r", R, 8'hFE);
        load(1'b1, 1'b1, 8'hF9);
        load(1'b1, 1'b0, 8'd100);
        op(1, 1'b0, 0);
        chk("lit_s100_n7_q", Q, 8'hF2);
        chk("lit_s100_n7_r", R, 8'd2);
        chk("lit_s100_n7_m", M, 8'd7);
        load(1'b1, 1'b1, 8'hFF);
        load(1'b1, 1'b0, 8'h80);
        op(1, 1'b0, 0);
        chk("lit_sn128_n1_q", Q, 8'h80);
        chk("lit_sn128_n1_r", R, 8'd0);
`endif

        edge_wait();
        edge_wait();
        e_chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
